ghost_typist: RTL and testbench



---
 rtl/ghost_typist_pkg.sv | 30 +++
 rtl/ghost_typist_scan_lut.sv | 22 ++
 rtl/ghost_typist.sv | 237 +++++++++++++++++++++++
 tb/tb_ghost_typist.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_typist_pkg.sv
// Shared definitions for the ghost typist and the scoring counter it feeds:
// letter-to-scan table, special key codes and the typist FSM state type.
package ghost_typist_pkg;

    localparam int CHAR_W = 5;
    localparam int SCAN_W = 9;

    localparam logic [SCAN_W-1:0] SCAN_SPACE = 9'd41;
    localparam logic [SCAN_W-1:0] SCAN_BACK  = 9'd102;

    // Indexed by letter code minus one (a = code 1).
    localparam logic [SCAN_W-1:0] LETTER_SCAN [26] = '{
        9'd28, 9'd50, 9'd33, 9'd35, 9'd36, 9'd43, 9'd52, 9'd51, 9'd67,
        9'd59, 9'd66, 9'd75, 9'd58, 9'd49, 9'd68, 9'd77, 9'd21, 9'd45,
        9'd27, 9'd44, 9'd60, 9'd42, 9'd29, 9'd34, 9'd53, 9'd26
    };

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        PRESS,
        HOLD,
        RELEASE,
        GAP,
        SPACE_P,
        SPACE_H,
        SPACE_R
    } ghost_state_t;

endpackage

// File: rtl/ghost_typist_scan_lut.sv
// Letter code to scan code lookup; codes outside 1..26 are flagged invalid
// and return scan code 0.
module ghost_scan_lut
    import ghost_typist_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [SCAN_W-1:0] scan,
    output logic              invalid
);

    always_comb begin
        scan    = '0;
        invalid = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (code == CHAR_W'(i + 1)) begin
                scan    = LETTER_SCAN[i];
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ghost_typist.sv
// Paced keystroke generator: types the target word as press/release key
// events, follows it with a space, then requests the next word.
module ghost_typist
    import ghost_typist_pkg::*;
#(
    parameter int HOLD_TICKS = 2,
    parameter int MAX_CHARS  = 15
) (
    input  logic                        clk_div,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [7:0]                  gap_ticks,
    input  logic [CHAR_W*MAX_CHARS-1:0] word,
    input  logic [4:0]                  wordnum,
    output logic [SCAN_W-1:0]           last_change,
    output logic                        key_valid,
    output logic                        key_pressed,
    output logic                        next_word,
    output logic [4:0]                  ghost_cursor,
    output logic [6:0]                  words_done,
    output logic                        busy
);

    ghost_state_t                state_reg, state_next;
    logic [CHAR_W*MAX_CHARS-1:0] word_reg, word_next;
    logic [4:0]                  len_reg, len_next;
    logic [4:0]                  cursor_reg, cursor_next;
    logic [7:0]                  cnt_reg, cnt_next;
    logic                        space_sent_reg, space_sent_next;
    logic                        first_load_reg, first_load_next;
    logic [SCAN_W-1:0]           last_change_reg, last_change_next;
    logic                        key_valid_reg, key_valid_next;
    logic                        key_pressed_reg, key_pressed_next;
    logic                        next_word_reg, next_word_next;
    logic [6:0]                  words_done_reg, words_done_next;
    logic                        busy_reg, busy_next;

    logic [CHAR_W-1:0] char_arr [32];
    logic [CHAR_W-1:0] cur_char;
    logic [SCAN_W-1:0] cur_scan;
    logic              cur_invalid;
    logic [4:0]        cursor_inc;
    logic [4:0]        len_in;
    logic [7:0]        gap_eff;
    logic              gap_single;
    logic [8:0]        cnt_plus2;
    logic              hold_done;
    logic              gap_done;

    // Cursor-indexed view of the captured word; slots past capacity read as 0.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_chars
            if (gi < MAX_CHARS) begin : g_used
                assign char_arr[gi] = word_reg[gi*CHAR_W +: CHAR_W];
            end else begin : g_pad
                assign char_arr[gi] = '0;
            end
        end
    endgenerate

    assign cur_char = char_arr[cursor_reg];

    ghost_scan_lut u_lut (
        .code    (cur_char),
        .scan    (cur_scan),
        .invalid (cur_invalid)
    );

    assign cursor_inc = cursor_reg + 5'd1;
    assign len_in     = (wordnum > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : wordnum;
    assign gap_eff    = (gap_ticks == 8'd0) ? 8'd1 : gap_ticks;
    assign gap_single = (gap_eff == 8'd1);
    assign cnt_plus2  = {1'b0, cnt_reg} + 9'd2;
    assign hold_done  = (cnt_plus2 >= 9'(HOLD_TICKS));
    assign gap_done   = (cnt_plus2 >= {1'b0, gap_eff});

    function automatic ghost_state_t after_gap(input logic [4:0] cursor,
                                               input logic [4:0] len,
                                               input logic       sent);
        if (cursor < len)
            return PRESS;
        else if (!sent)
            return SPACE_P;
        else
            return LOAD;
    endfunction

    always_comb begin
        state_next       = state_reg;
        word_next        = word_reg;
        len_next         = len_reg;
        cursor_next      = cursor_reg;
        cnt_next         = '0;
        space_sent_next  = space_sent_reg;
        first_load_next  = first_load_reg;
        last_change_next = last_change_reg;
        key_valid_next   = 1'b0;
        key_pressed_next = key_pressed_reg;
        next_word_next   = 1'b0;
        words_done_next  = words_done_reg;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next      = LOAD;
                    first_load_next = 1'b1;
                end
            end
            LOAD: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    word_next       = word;
                    len_next        = len_in;
                    cursor_next     = '0;
                    space_sent_next = 1'b0;
                    if (first_load_reg) begin
                        words_done_next = '0;
                        first_load_next = 1'b0;
                    end
                    state_next = (len_in == 5'd0) ? SPACE_P : PRESS;
                end
            end
            PRESS: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (cur_invalid) begin
                    cursor_next = cursor_inc;
                    state_next  = gap_single ? after_gap(cursor_inc, len_reg, space_sent_reg) : GAP;
                end else begin
                    key_valid_next   = 1'b1;
                    key_pressed_next = 1'b1;
                    last_change_next = cur_scan;
                    state_next       = (HOLD_TICKS <= 1) ? RELEASE : HOLD;
                end
            end
            HOLD, SPACE_H: begin
                // A held key is always released, even when aborting.
                if (!enable) begin
                    key_valid_next   = 1'b1;
                    key_pressed_next = 1'b0;
                    state_next       = IDLE;
                end else if (hold_done) begin
                    state_next = (state_reg == HOLD) ? RELEASE : SPACE_R;
                end
            end
            RELEASE: begin
                key_valid_next   = 1'b1;
                key_pressed_next = 1'b0;
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    cursor_next = cursor_inc;
                    state_next  = gap_single ? after_gap(cursor_inc, len_reg, space_sent_reg) : GAP;
                end
            end
            GAP: begin
                if (!enable)
                    state_next = IDLE;
                else if (gap_done)
                    state_next = after_gap(cursor_reg, len_reg, space_sent_reg);
            end
            SPACE_P: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    key_valid_next   = 1'b1;
                    key_pressed_next = 1'b1;
                    last_change_next = SCAN_SPACE;
                    state_next       = (HOLD_TICKS <= 1) ? SPACE_R : SPACE_H;
                end
            end
            SPACE_R: begin
                key_valid_next   = 1'b1;
                key_pressed_next = 1'b0;
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    next_word_next  = 1'b1;
                    words_done_next = (words_done_reg == 7'd127) ? words_done_reg
                                                                 : words_done_reg + 7'd1;
                    space_sent_next = 1'b1;
                    state_next      = gap_single ? LOAD : GAP;
                end
            end
            default: state_next = IDLE;
        endcase

        // The hold/gap counter only runs while dwelling in a timed state.
        if (state_next == state_reg &&
            (state_reg == HOLD || state_reg == SPACE_H || state_reg == GAP))
            cnt_next = cnt_reg + 8'd1;
    end

    assign busy_next = (state_next != IDLE);

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            word_reg        <= '0;
            len_reg         <= '0;
            cursor_reg      <= '0;
            cnt_reg         <= '0;
            space_sent_reg  <= 1'b0;
            first_load_reg  <= 1'b0;
            last_change_reg <= '0;
            key_valid_reg   <= 1'b0;
            key_pressed_reg <= 1'b0;
            next_word_reg   <= 1'b0;
            words_done_reg  <= '0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            word_reg        <= word_next;
            len_reg         <= len_next;
            cursor_reg      <= cursor_next;
            cnt_reg         <= cnt_next;
            space_sent_reg  <= space_sent_next;
            first_load_reg  <= first_load_next;
            last_change_reg <= last_change_next;
            key_valid_reg   <= key_valid_next;
            key_pressed_reg <= key_pressed_next;
            next_word_reg   <= next_word_next;
            words_done_reg  <= words_done_next;
            busy_reg        <= busy_next;
        end
    end

    assign last_change  = last_change_reg;
    assign key_valid    = key_valid_reg;
    assign key_pressed  = key_pressed_reg;
    assign next_word    = next_word_reg;
    assign ghost_cursor = cursor_reg;
    assign words_done   = words_done_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_ghost_typist.sv
// Bench for ghost_typist: directed scenarios from the typing rules plus
// randomized words checked tick by tick against an event-schedule model.
module tb_ghost_typist;

    localparam int H    = 2;
    localparam int MAXT = 1024;

    logic        clk_div = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  gap_ticks;
    logic [74:0] word;
    logic [4:0]  wordnum;
    logic [8:0]  last_change;
    logic        key_valid;
    logic        key_pressed;
    logic        next_word;
    logic [4:0]  ghost_cursor;
    logic [6:0]  words_done;
    logic        busy;

    ghost_typist #(.HOLD_TICKS(H), .MAX_CHARS(15)) dut (
        .clk_div      (clk_div),
        .rst          (rst),
        .enable       (enable),
        .gap_ticks    (gap_ticks),
        .word         (word),
        .wordnum      (wordnum),
        .last_change  (last_change),
        .key_valid    (key_valid),
        .key_pressed  (key_pressed),
        .next_word    (next_word),
        .ghost_cursor (ghost_cursor),
        .words_done   (words_done),
        .busy         (busy)
    );

    always #5 clk_div = ~clk_div;

    int n_tests = 0;
    int n_fail  = 0;
    int scen_no = 0;

    int scan_tab [26] = '{28, 50, 33, 35, 36, 43, 52, 51, 67, 59, 66, 75, 58,
                          49, 68, 77, 21, 45, 27, 44, 60, 42, 29, 34, 53, 26};

    logic [74:0] words_q [8];
    int          nums    [8];

    bit kv_e [MAXT];
    int code_e [MAXT];
    bit pr_e [MAXT];
    bit nw_e [MAXT];
    bit cs_e [MAXT];
    int cv_e [MAXT];

    int obs_t[$], obs_c[$], obs_p[$], obs_nw[$];
    int et[$], ec[$], ep[$];
    int mdl_code = 0;
    int mdl_pr   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [74:0] make_word(input int a, input int b, input int c);
        logic [74:0] w = '0;
        w[4:0]   = 5'(a);
        w[9:5]   = 5'(b);
        w[14:10] = 5'(c);
        return w;
    endfunction

    task automatic rand_word(input int j);
        for (int i = 0; i < 15; i++) begin
            int c;
            if ($urandom_range(0, 7) == 0) c = int'($urandom_range(0, 31));
            else                           c = int'($urandom_range(1, 26));
            words_q[j][5*i +: 5] = 5'(c);
        end
        if ($urandom_range(0, 5) == 0) nums[j] = int'($urandom_range(0, 31));
        else                           nums[j] = int'($urandom_range(1, 6));
    endtask

    // Builds the expected schedule with enable rising before tick 0 and
    // falling before tick d, then runs the DUT and compares every tick.
    task automatic run_scenario(input int g_in, input int d_in, input int nwords);
        int g, t, d, r_last, widx, wd_m, cur_m;
        int ev_p[$], ev_r[$], ev_c[$], nw_q[$], cs_t[$], cs_v[$];
        g = (g_in < 1) ? 1 : g_in;
        t = 2;
        r_last = 2;
        cs_t.push_back(1);
        cs_v.push_back(0);
        for (int j = 0; j < nwords; j++) begin
            int len;
            len = (nums[j] > 15) ? 15 : nums[j];
            for (int c = 0; c < len; c++) begin
                int code;
                code = int'(words_q[j][5*c +: 5]);
                if (code >= 1 && code <= 26) begin
                    ev_p.push_back(t);
                    ev_r.push_back(t + H);
                    ev_c.push_back(scan_tab[code-1]);
                    cs_t.push_back(t + H);
                    cs_v.push_back(c + 1);
                    t += H + g;
                end else begin
                    cs_t.push_back(t);
                    cs_v.push_back(c + 1);
                    t += g;
                end
            end
            ev_p.push_back(t);
            ev_r.push_back(t + H);
            ev_c.push_back(41);
            nw_q.push_back(t + H);
            r_last = t + H;
            cs_t.push_back(t + H + g);
            cs_v.push_back(0);
            t = t + H + g + 1;
        end
        d = (d_in > 0) ? d_in : int'($urandom_range(2, r_last + g + 1));

        for (int k = 0; k < MAXT; k++) begin
            kv_e[k] = 0; code_e[k] = 0; pr_e[k] = 0; nw_e[k] = 0; cs_e[k] = 0; cv_e[k] = 0;
        end
        for (int i = 0; i < ev_p.size(); i++) begin
            if (ev_p[i] < d) begin
                int rr;
                kv_e[ev_p[i]] = 1; code_e[ev_p[i]] = ev_c[i]; pr_e[ev_p[i]] = 1;
                rr = (ev_r[i] < d) ? ev_r[i] : d;
                kv_e[rr] = 1; code_e[rr] = ev_c[i]; pr_e[rr] = 0;
            end
        end
        foreach (nw_q[i]) if (nw_q[i] < d) nw_e[nw_q[i]] = 1;
        foreach (cs_t[i]) if (cs_t[i] < d) begin cs_e[cs_t[i]] = 1; cv_e[cs_t[i]] = cs_v[i]; end

        obs_t.delete(); obs_c.delete(); obs_p.delete(); obs_nw.delete();
        @(negedge clk_div);
        widx      = 0;
        word      = words_q[0];
        wordnum   = 5'(nums[0]);
        gap_ticks = 8'(g_in);
        wd_m      = 0;
        cur_m     = 0;
        for (int k = 0; k <= d + 4; k++) begin
            enable = (k < d);
            @(posedge clk_div);
            #1;
            if (kv_e[k]) begin mdl_code = code_e[k]; mdl_pr = int'(pr_e[k]); end
            if (nw_e[k] && wd_m < 127) wd_m++;
            if (cs_e[k]) cur_m = cv_e[k];
            check_val($sformatf("key_valid@%0d", k), int'(key_valid), int'(kv_e[k]));
            check_val($sformatf("last_change@%0d", k), int'(last_change), mdl_code);
            check_val($sformatf("key_pressed@%0d", k), int'(key_pressed), mdl_pr);
            check_val($sformatf("next_word@%0d", k), int'(next_word), int'(nw_e[k]));
            check_val($sformatf("busy@%0d", k), int'(busy), (k < d) ? 1 : 0);
            if (k >= 1) begin
                check_val($sformatf("ghost_cursor@%0d", k), int'(ghost_cursor), cur_m);
                check_val($sformatf("words_done@%0d", k), int'(words_done), wd_m);
            end
            if (key_valid) begin
                obs_t.push_back(k);
                obs_c.push_back(int'(last_change));
                obs_p.push_back(int'(key_pressed));
            end
            if (next_word) begin
                obs_nw.push_back(k);
                if (widx < 7) widx++;
                word    = words_q[widx];
                wordnum = 5'(nums[widx]);
            end
            @(negedge clk_div);
        end
        scen_no++;
        $display("[TB] scenario %0d: gap=%0d words=%0d abort_tick=%0d events=%0d",
                 scen_no, g_in, nwords, d, obs_t.size());
    endtask

    task automatic check_events(input string tag);
        check_val({tag, "_count"}, obs_t.size(), et.size());
        for (int i = 0; i < et.size(); i++) begin
            if (i < obs_t.size()) begin
                check_val($sformatf("%s_tick%0d", tag, i), obs_t[i], et[i]);
                check_val($sformatf("%s_code%0d", tag, i), obs_c[i], ec[i]);
                check_val($sformatf("%s_press%0d", tag, i), obs_p[i], ep[i]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        gap_ticks = '0;
        word      = '0;
        wordnum   = '0;
        repeat (2) @(negedge clk_div);
        check_val("rst_last_change", int'(last_change), 0);
        check_val("rst_key_valid", int'(key_valid), 0);
        check_val("rst_key_pressed", int'(key_pressed), 0);
        check_val("rst_next_word", int'(next_word), 0);
        check_val("rst_ghost_cursor", int'(ghost_cursor), 0);
        check_val("rst_words_done", int'(words_done), 0);
        check_val("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // "cat" with gap 3: first press at tick 2
        words_q[0] = make_word(3, 1, 20); nums[0] = 3;
        words_q[1] = '0;                  nums[1] = 0;
        run_scenario(3, 22, 1);
        et = {2, 4, 7, 9, 12, 14, 17, 19};
        ec = {33, 33, 28, 28, 44, 44, 41, 41};
        ep = {1, 0, 1, 0, 1, 0, 1, 0};
        check_events("cat");
        check_val("cat_nw_count", obs_nw.size(), 1);
        if (obs_nw.size() > 0) check_val("cat_nw_tick", obs_nw[0], 19);
        check_val("cat_words_done", int'(words_done), 1);

        // empty word: only the space
        words_q[0] = make_word(5, 5, 5); nums[0] = 0;
        run_scenario(2, 6, 1);
        et = {2, 4}; ec = {41, 41}; ep = {1, 0};
        check_events("empty");
        check_val("empty_cursor", int'(ghost_cursor), 0);

        // invalid letter in the middle: "a?b"
        words_q[0] = make_word(1, 0, 2); nums[0] = 3;
        run_scenario(2, 16, 1);
        et = {2, 4, 8, 10, 12, 14}; ec = {28, 28, 50, 50, 41, 41}; ep = {1, 0, 1, 0, 1, 0};
        check_events("inval");
        check_val("inval_cursor", int'(ghost_cursor), 3);

        // enable dropped while 'c' is held
        words_q[0] = make_word(3, 1, 20); nums[0] = 3;
        run_scenario(3, 3, 1);
        et = {2, 3}; ec = {33, 33}; ep = {1, 0};
        check_events("abort");
        check_val("abort_busy", int'(busy), 0);

        // gap 0 and gap 1 give the same one-tick spacing
        words_q[0] = make_word(1, 2, 0); nums[0] = 2;
        et = {2, 4, 5, 7, 8, 10}; ec = {28, 28, 50, 50, 41, 41}; ep = {1, 0, 1, 0, 1, 0};
        run_scenario(0, 11, 1);
        check_events("gap0");
        run_scenario(1, 11, 1);
        check_events("gap1");

        // asynchronous reset in the middle of a held key
        @(negedge clk_div);
        word = make_word(3, 1, 20); wordnum = 5'd3; gap_ticks = 8'd3; enable = 1'b1;
        repeat (3) @(posedge clk_div);
        #1;
        check_val("rsth_press", int'(key_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("rsth_last_change", int'(last_change), 0);
        check_val("rsth_key_valid", int'(key_valid), 0);
        check_val("rsth_key_pressed", int'(key_pressed), 0);
        check_val("rsth_next_word", int'(next_word), 0);
        check_val("rsth_ghost_cursor", int'(ghost_cursor), 0);
        check_val("rsth_words_done", int'(words_done), 0);
        check_val("rsth_busy", int'(busy), 0);
        enable = 1'b0;
        @(negedge clk_div);
        rst      = 1'b0;
        mdl_code = 0;
        mdl_pr   = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_div);
            #1;
            check_val($sformatf("rsth_quiet_kv%0d", i), int'(key_valid), 0);
            check_val($sformatf("rsth_quiet_busy%0d", i), int'(busy), 0);
        end
        $display("[TB] reset mid-hold scenario done");

        // randomized words, gaps and abort points
        for (int s = 0; s < 40; s++) begin
            int nw;
            nw = int'($urandom_range(1, 3));
            for (int j = 0; j <= nw; j++) rand_word(j);
            run_scenario(int'($urandom_range(0, 5)), 0, nw);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
